// File: rtl/receive_data.sv
// -----------------------------------------------------------------------------
// receive_data
//
// Purpose:
//   Parses fixed-length command frames arriving from the UART receiver and
//   applies them to the game logic. Frame format is SYNC (0xFF), TYPE, PAYLOAD
//   and, when RX_CHECKSUM_EN is defined, a CHECK byte equal to
//   TYPE ^ PAYLOAD ^ 0x5A. Accepted frames update the game-state or target
//   registers, issue an operate-command strobe, or push a byte into a small
//   first-word-fall-through script FIFO. Rejected frames and mid-frame
//   timeouts are counted in a saturating error counter.
//
// Optional feature macro: RX_CHECKSUM_EN (adds the CHECK byte and GET_CHECK).
//
// Parameters:
//   SCRIPT_DEPTH    script FIFO depth, power of 2, >= 2
//   TIMEOUT_CYCLES  idle cycles tolerated between bytes inside a frame
//
// Ports:
//   uart_clk      in   clock, all state changes on the rising edge
//   rst           in   asynchronous active-high reset
//   rx_data[7:0]  in   received byte, valid while rx_valid=1
//   rx_valid      in   one-cycle strobe per received byte
//   game_state    out  last committed game-state byte
//   target        out  last committed target byte
//   op_cmd        out  last committed operate command
//   op_valid      out  one-cycle pulse when op_cmd is updated
//   script_data   out  FIFO head byte (0x00 while empty)
//   script_valid  out  FIFO not empty
//   script_ready  in   consumer pops the head when script_valid & script_ready
//   frame_ok      out  one-cycle pulse per accepted frame
//   err_count     out  saturating count of rejected frames and timeouts
//   overflow      out  sticky, set on a script push while the FIFO is full
// -----------------------------------------------------------------------------
module receive_data #(
    parameter int SCRIPT_DEPTH   = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       uart_clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] game_state,
    output logic [7:0] target,
    output logic [7:0] op_cmd,
    output logic       op_valid,
    output logic [7:0] script_data,
    output logic       script_valid,
    input  logic       script_ready,
    output logic       frame_ok,
    output logic [7:0] err_count,
    output logic       overflow
);

    localparam int PTR_W = $clog2(SCRIPT_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] SYNC_BYTE    = 8'hFF;
    localparam logic [7:0] TYPE_STATE   = 8'h01;
    localparam logic [7:0] TYPE_TARGET  = 8'h02;
    localparam logic [7:0] TYPE_OPERATE = 8'h03;
    localparam logic [7:0] TYPE_SCRIPT  = 8'h04;

`ifdef RX_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, GET_TYPE, GET_PAYLOAD, GET_CHECK, COMMIT} state_t;
`else
    typedef enum logic [2:0] {IDLE, GET_TYPE, GET_PAYLOAD, COMMIT} state_t;
`endif

    state_t            state_reg;
    logic [7:0]        type_reg;
    logic [7:0]        payload_reg;
`ifdef RX_CHECKSUM_EN
    logic [7:0]        check_reg;
`endif
    logic [TO_W-1:0]   timer_reg;

    // Script FIFO storage and bookkeeping
    logic [7:0]        fifo_mem [SCRIPT_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    logic fifo_full;
    logic pop;
    logic push;
    logic in_frame;
    logic timeout;
    logic sync_seen;
    logic in_commit;
    logic check_good;
    logic type_known;
    logic fifo_blocked;
    logic accept;
    logic reject;
    logic overflow_set;
    logic err_inc;

    // ------------------------------------------------------------------
    // FIFO status; head is read combinationally for first-word fall-through
    // ------------------------------------------------------------------
    assign script_valid = (count_reg != '0);
    assign fifo_full    = (count_reg == CNT_W'(SCRIPT_DEPTH));
    assign pop          = script_valid & script_ready;
    assign script_data  = script_valid ? fifo_mem[rd_ptr_reg] : 8'h00;

    // ------------------------------------------------------------------
    // Frame parsing helpers
    // ------------------------------------------------------------------
    assign sync_seen = rx_valid && (rx_data == SYNC_BYTE);

`ifdef RX_CHECKSUM_EN
    assign in_frame   = (state_reg == GET_TYPE) || (state_reg == GET_PAYLOAD) ||
                        (state_reg == GET_CHECK);
    assign check_good = (check_reg == (type_reg ^ payload_reg ^ 8'h5A));
`else
    assign in_frame   = (state_reg == GET_TYPE) || (state_reg == GET_PAYLOAD);
    assign check_good = 1'b1;
`endif

    // A byte arriving in the same cycle as the limit keeps the frame alive.
    assign timeout = in_frame && !rx_valid &&
                     (timer_reg == TO_W'(TIMEOUT_CYCLES - 1));

    // ------------------------------------------------------------------
    // COMMIT decision
    // ------------------------------------------------------------------
    assign in_commit    = (state_reg == COMMIT);
    assign type_known   = (type_reg >= TYPE_STATE) && (type_reg <= TYPE_SCRIPT);
    // A pop in the same cycle frees the slot, so a full FIFO only blocks
    // when nothing is leaving.
    assign fifo_blocked = (type_reg == TYPE_SCRIPT) && fifo_full && !pop;
    assign accept       = in_commit && check_good && type_known && !fifo_blocked;
    assign reject       = in_commit && !accept;
    assign push         = accept && (type_reg == TYPE_SCRIPT);
    // A frame failing its checksum never touches the FIFO, so it cannot
    // raise overflow either.
    assign overflow_set = in_commit && check_good && fifo_blocked;
    // reject and timeout live in different states, so at most one fires.
    assign err_inc      = reject || timeout;

    // ------------------------------------------------------------------
    // FIFO storage (no reset; validity is tracked by count_reg)
    // ------------------------------------------------------------------
    always_ff @(posedge uart_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= payload_reg;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM, output registers, counters and FIFO pointers
    // ------------------------------------------------------------------
    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            type_reg    <= 8'h00;
            payload_reg <= 8'h00;
`ifdef RX_CHECKSUM_EN
            check_reg   <= 8'h00;
`endif
            timer_reg   <= '0;
            game_state  <= 8'h00;
            target      <= 8'h00;
            op_cmd      <= 8'h00;
            op_valid    <= 1'b0;
            frame_ok    <= 1'b0;
            err_count   <= 8'h00;
            overflow    <= 1'b0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
        end else begin
            // Inter-byte timer: runs only while a frame is in progress.
            if (rx_valid || !in_frame || timeout) begin
                timer_reg <= '0;
            end else begin
                timer_reg <= timer_reg + 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (sync_seen) state_reg <= GET_TYPE;
                end
                GET_TYPE: begin
                    if (timeout) begin
                        state_reg <= IDLE;
                    end else if (sync_seen) begin
                        state_reg <= GET_TYPE;
                    end else if (rx_valid) begin
                        type_reg  <= rx_data;
                        state_reg <= GET_PAYLOAD;
                    end
                end
                GET_PAYLOAD: begin
                    if (timeout) begin
                        state_reg <= IDLE;
                    end else if (sync_seen) begin
                        state_reg <= GET_TYPE;
                    end else if (rx_valid) begin
                        payload_reg <= rx_data;
`ifdef RX_CHECKSUM_EN
                        state_reg   <= GET_CHECK;
`else
                        state_reg   <= COMMIT;
`endif
                    end
                end
`ifdef RX_CHECKSUM_EN
                GET_CHECK: begin
                    if (timeout) begin
                        state_reg <= IDLE;
                    end else if (sync_seen) begin
                        state_reg <= GET_TYPE;
                    end else if (rx_valid) begin
                        check_reg <= rx_data;
                        state_reg <= COMMIT;
                    end
                end
`endif
                COMMIT: begin
                    // A SYNC landing on the commit cycle starts the next frame.
                    state_reg <= sync_seen ? GET_TYPE : IDLE;
                end
                default: state_reg <= IDLE;
            endcase

            // Commit actions
            frame_ok <= accept;
            op_valid <= accept && (type_reg == TYPE_OPERATE);
            if (accept) begin
                case (type_reg)
                    TYPE_STATE:   game_state <= payload_reg;
                    TYPE_TARGET:  target     <= payload_reg;
                    TYPE_OPERATE: op_cmd     <= payload_reg;
                    default: ;
                endcase
            end

            if (overflow_set) overflow <= 1'b1;

            if (err_inc && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end

            // FIFO pointers wrap naturally since the depth is a power of 2.
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_receive_data.sv
// -----------------------------------------------------------------------------
// tb_receive_data
//
// Self-checking bench for receive_data. Frame results are compared from a
// vector table; op_cmd strobes and script FIFO pops are checked against
// scoreboard queues filled when the corresponding frames are sent. Builds with
// or without RX_CHECKSUM_EN; the CHECK byte is appended automatically.
// -----------------------------------------------------------------------------
module tb_receive_data;

    localparam int DEPTH = 8;
    localparam int TMO   = 16;

    logic       uart_clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] game_state;
    logic [7:0] target;
    logic [7:0] op_cmd;
    logic       op_valid;
    logic [7:0] script_data;
    logic       script_valid;
    logic       script_ready;
    logic       frame_ok;
    logic [7:0] err_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] op_q[$];
    logic [7:0] scr_q[$];

    typedef struct {
        logic [7:0] typ;
        logic [7:0] pay;
        logic       ok;
        logic [7:0] gs;
        logic [7:0] tg;
        logic [7:0] err;
    } vec_t;

    vec_t vecs[9];

    receive_data #(
        .SCRIPT_DEPTH  (DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .uart_clk    (uart_clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .game_state  (game_state),
        .target      (target),
        .op_cmd      (op_cmd),
        .op_valid    (op_valid),
        .script_data (script_data),
        .script_valid(script_valid),
        .script_ready(script_ready),
        .frame_ok    (frame_ok),
        .err_count   (err_count),
        .overflow    (overflow)
    );

    always #5 uart_clk = ~uart_clk;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    // Advance one cycle. Scoreboard checks run on the values present at this
    // negedge, with inputs already stable for the coming rising edge.
    task automatic tick();
        if (op_valid === 1'b1) begin
            if (op_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL op_unexpected: op_valid high with op_cmd=%02h, expected no strobe", op_cmd);
            end else begin
                check8("op_scoreboard", op_cmd, op_q.pop_front());
            end
        end
        if (script_valid === 1'b1 && script_ready === 1'b1) begin
            if (scr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL script_unexpected: pop of %02h, expected empty FIFO", script_data);
            end else begin
                check8("script_scoreboard", script_data, scr_q.pop_front());
            end
        end
        @(negedge uart_clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] t, input logic [7:0] p);
        send_byte(8'hFF);
        send_byte(t);
        send_byte(p);
`ifdef RX_CHECKSUM_EN
        send_byte(t ^ p ^ 8'h5A);
`endif
    endtask

    task automatic check_reset(input string tag);
        check8({tag, "_game_state"},   game_state,   8'h00);
        check8({tag, "_target"},       target,       8'h00);
        check8({tag, "_op_cmd"},       op_cmd,       8'h00);
        check8({tag, "_err_count"},    err_count,    8'h00);
        check8({tag, "_op_valid"},     8'(op_valid),     8'h00);
        check8({tag, "_frame_ok"},     8'(frame_ok),     8'h00);
        check8({tag, "_overflow"},     8'(overflow),     8'h00);
        check8({tag, "_script_valid"}, 8'(script_valid), 8'h00);
        check8({tag, "_script_data"},  script_data,  8'h00);
    endtask

    initial begin
        logic [7:0] b;

        vecs[0] = '{8'h01, 8'h3C, 1'b1, 8'h3C, 8'h00, 8'h00};
        vecs[1] = '{8'h02, 8'h55, 1'b1, 8'h3C, 8'h55, 8'h00};
        vecs[2] = '{8'h03, 8'h81, 1'b1, 8'h3C, 8'h55, 8'h00};
        vecs[3] = '{8'h09, 8'h11, 1'b0, 8'h3C, 8'h55, 8'h01};
        vecs[4] = '{8'h01, 8'h00, 1'b1, 8'h00, 8'h55, 8'h01};
        vecs[5] = '{8'h03, 8'h7E, 1'b1, 8'h00, 8'h55, 8'h01};
        vecs[6] = '{8'h00, 8'h42, 1'b0, 8'h00, 8'h55, 8'h02};
        vecs[7] = '{8'h04, 8'hA5, 1'b1, 8'h00, 8'h55, 8'h02};
        vecs[8] = '{8'h02, 8'h00, 1'b1, 8'h00, 8'h00, 8'h02};

        rst          = 1'b1;
        rx_data      = 8'h00;
        rx_valid     = 1'b0;
        script_ready = 1'b0;
        tick();
        tick();
        check_reset("reset");
        rst = 1'b0;
        tick();

        // Table-driven frames
        for (int i = 0; i < 9; i++) begin
            send_frame(vecs[i].typ, vecs[i].pay);
            if (vecs[i].ok && vecs[i].typ == 8'h03) op_q.push_back(vecs[i].pay);
            if (vecs[i].ok && vecs[i].typ == 8'h04) scr_q.push_back(vecs[i].pay);
            tick();
            check8($sformatf("vec%0d_frame_ok", i),   8'(frame_ok), 8'(vecs[i].ok));
            check8($sformatf("vec%0d_game_state", i), game_state,   vecs[i].gs);
            check8($sformatf("vec%0d_target", i),     target,       vecs[i].tg);
            check8($sformatf("vec%0d_err_count", i),  err_count,    vecs[i].err);
            check8($sformatf("vec%0d_op_valid", i),   8'(op_valid),
                   8'(vecs[i].ok && vecs[i].typ == 8'h03));
            $display("frame %0d type=%02h payload=%02h frame_ok=%0b gs=%02h tg=%02h err=%02h",
                     i, vecs[i].typ, vecs[i].pay, frame_ok, game_state, target, err_count);
            tick();
            check8($sformatf("vec%0d_frame_ok_fall", i), 8'(frame_ok), 8'h00);
        end
        check8("table_script_valid", 8'(script_valid), 8'h01);
        check8("table_script_data",  script_data,      8'hA5);

        // Reset in the middle of a frame discards everything
        send_byte(8'hFF);
        send_byte(8'h01);
        rst = 1'b1;
        tick();
        check_reset("mid_reset");
        scr_q.delete();
        op_q.delete();
        rst = 1'b0;
        tick();
        send_byte(8'h3C);
        tick();
        check8("stray_payload_ignored", game_state, 8'h00);
        send_frame(8'h01, 8'h3C);
        tick();
        check8("post_reset_game_state", game_state,   8'h3C);
        check8("post_reset_frame_ok",   8'(frame_ok), 8'h01);
        $display("frame post-reset type=01 payload=3C gs=%02h", game_state);
        tick();
        check8("post_reset_frame_ok_fall", 8'(frame_ok), 8'h00);

        // FIFO fill and overflow with the consumer stalled
        for (int n = 0; n < 9; n++) begin
            b = 8'h10 + 8'(n);
            send_frame(8'h04, b);
            if (n < DEPTH) scr_q.push_back(b);
            tick();
            check8($sformatf("fill%0d_frame_ok", n), 8'(frame_ok), 8'(n < DEPTH));
            $display("script frame %0d payload=%02h frame_ok=%0b overflow=%0b", n, b, frame_ok, overflow);
            tick();
        end
        check8("fill_overflow",     8'(overflow),     8'h01);
        check8("fill_err_count",    err_count,        8'h01);
        check8("fill_script_valid", 8'(script_valid), 8'h01);
        check8("fill_head",         script_data,      8'h10);
        script_ready = 1'b1;
        repeat (DEPTH) tick();
        script_ready = 1'b0;
        check8("drain_script_valid", 8'(script_valid), 8'h00);
        check8("drain_queue_empty",  8'(scr_q.size()), 8'h00);
        check8("overflow_sticky",    8'(overflow),     8'h01);

        // Resync on a repeated SYNC, then an unknown type
        send_byte(8'hFF);
        send_byte(8'h02);
        send_frame(8'h02, 8'h55);
        tick();
        check8("resync_target",   target,       8'h55);
        check8("resync_err",      err_count,    8'h01);
        check8("resync_frame_ok", 8'(frame_ok), 8'h01);
        tick();
        send_frame(8'h09, 8'h11);
        tick();
        check8("unknown_err",      err_count,    8'h02);
        check8("unknown_target",   target,       8'h55);
        check8("unknown_gs",       game_state,   8'h3C);
        check8("unknown_frame_ok", 8'(frame_ok), 8'h00);
        tick();

        // One cycle short of the timeout: frame still completes
        send_byte(8'hFF);
        send_byte(8'h01);
        repeat (TMO - 1) tick();
        send_byte(8'h66);
`ifdef RX_CHECKSUM_EN
        send_byte(8'h01 ^ 8'h66 ^ 8'h5A);
`endif
        tick();
        check8("late_ok_gs",       game_state,   8'h66);
        check8("late_ok_err",      err_count,    8'h02);
        check8("late_ok_frame_ok", 8'(frame_ok), 8'h01);
        tick();

        // Full timeout: frame aborted, late payload ignored
        send_byte(8'hFF);
        send_byte(8'h01);
        repeat (TMO) tick();
        check8("timeout_err", err_count, 8'h03);
        send_byte(8'h22);
`ifdef RX_CHECKSUM_EN
        send_byte(8'h01 ^ 8'h22 ^ 8'h5A);
`endif
        tick();
        check8("timeout_gs",       game_state,   8'h66);
        check8("timeout_frame_ok", 8'(frame_ok), 8'h00);
        check8("timeout_err_hold", err_count,    8'h03);
        tick();

`ifdef RX_CHECKSUM_EN
        // Bad checksum is rejected
        send_byte(8'hFF);
        send_byte(8'h01);
        send_byte(8'h3C);
        send_byte(8'h00);
        tick();
        check8("badchk_gs",       game_state,   8'h66);
        check8("badchk_err",      err_count,    8'h04);
        check8("badchk_frame_ok", 8'(frame_ok), 8'h00);
        tick();
`endif

        // Drive err_count into saturation and past it
        for (int k = 0; k < 260; k++) begin
`ifdef RX_CHECKSUM_EN
            send_byte(8'hFF);
            send_byte(8'h01);
            send_byte(8'h3C);
            send_byte(8'h00);
`else
            send_frame(8'h09, 8'h11);
`endif
            tick();
            tick();
        end
        check8("saturate_err", err_count, 8'hFF);
        check8("saturate_gs",  game_state, 8'h66);
        $display("saturation run done err=%02h", err_count);

        tick();
        check8("op_queue_empty",     8'(op_q.size()),  8'h00);
        check8("script_queue_empty", 8'(scr_q.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
